fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries and maximum outstanding-plus-buffered requests (power of 2, >=2).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low (rst=0 resets).
REQ-005 imem_req_valid  out  1  fetch request to instruction memory.
REQ-006 imem_req_ready  in  1  memory accepts request this cycle.
REQ-007 imem_addr  out  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  in  1  in-order read data returned this cycle.
REQ-009 imem_rsp_data  in  32  returned instruction word.
REQ-010 redirect  in  1  taken branch/jump from later stage; one-cycle pulse.
REQ-011 redirect_pc  in  32  new fetch target, sampled when redirect=1.
REQ-012 out_valid  out  1  next_instruction for decode is valid.
REQ-013 out_ready  in  1  decode consumes instruction this cycle.
REQ-014 next_instruction  out  32  instruction word at buffer head, 32'h0 when empty.
REQ-015 instr_pc  out  32  address of next_instruction, 32'h0 when empty.

Function
REQ-016 FSM states: FETCH (issue requests) and DRAIN (discard stale responses); reset state FETCH.
REQ-017 In FETCH, imem_req_valid SHALL be 1 iff outstanding + buffer occupancy < DEPTH and redirect=0.
REQ-018 A request is accepted when imem_req_valid && imem_req_ready; fetch_pc then advances by 4, outstanding increments.
REQ-019 imem_addr = fetch_pc; held stable while imem_req_valid=1 and not accepted.
REQ-020 fetch_pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0.
REQ-021 In FETCH, each imem_rsp_valid pushes {rsp_pc, imem_rsp_data} into the buffer, rsp_pc advances by 4, outstanding decrements.
REQ-022 Buffer is FIFO; out_valid = not empty; pop on out_valid && out_ready; latency request-accept to out_valid = memory latency + 1 cycle.
REQ-023 Simultaneous push and pop on full buffer is impossible by REQ-017 credit rule; simultaneous push and pop otherwise keeps occupancy constant.
REQ-024 On redirect: fetch_pc and rsp_pc <= {redirect_pc[31:2],2'b00}; buffer flushed; out_valid=0 next cycle.
REQ-025 On redirect, next state is DRAIN if outstanding (after this cycle's accept/response) > 0, else FETCH.
REQ-026 A request accepted in the redirect cycle counts as outstanding and is drained; a response arriving in the redirect cycle is discarded.
REQ-027 In DRAIN, imem_req_valid=0; each imem_rsp_valid is discarded and decrements outstanding; move to FETCH the cycle after outstanding reaches 0.
REQ-028 Redirect while in DRAIN reloads fetch_pc/rsp_pc and remains in DRAIN per REQ-025.
REQ-029 imem_rsp_valid with outstanding=0 is ignored (protocol error, no state change).

Reset
REQ-030 On rst=0 asynchronously: fetch_pc=rsp_pc=RESET_PC, outstanding=0, buffer empty, state FETCH, imem_req_valid=0, out_valid=0, next_instruction=0, instr_pc=0.
REQ-031 Reset mid-transaction abandons outstanding requests; first request after release is RESET_PC.

Structure
REQ-032 Shared package holds XLEN=32, INSTR_BYTES=4, default RESET_PC, FSM state enum.
REQ-033 Buffer implemented as sub-module fetch_fifo (synchronous, DEPTH entries of 64 bits, push/pop/flush, full/empty/count).

Verification
REQ-034 Reset release, ready=1, 1-cycle memory: addresses 0,4,8 issued; decode sees pc 0,4,8 with matching data in order.
REQ-035 out_ready=0 for 10 cycles: at most DEPTH requests issued, no overflow, order preserved on release.
REQ-036 Redirect to 32'h0000_0103 with 2 outstanding: both responses dropped, next request 32'h0000_0100, instr_pc 32'h100 first.
REQ-037 Redirect coincident with accept and response: no stale instruction reaches decode.
REQ-038 fetch_pc at 32'hFFFF_FFFC: next request address 32'h0000_0000.
REQ-039 rst asserted with outstanding=2: all outputs 0 immediately; first request after release is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, FSM state type and PC helpers for the instruction fetch unit.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Wraps modulo 2^XLEN by construction.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO with combinational head, push/pop and
// a flush that wins over both.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];
    assign do_push     = push_i && !full_o && !flush_i;
    assign do_pop      = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed when count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: credit-limited request issue, in-order response buffering
// and redirect handling that drains stale in-flight responses.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] next_instruction,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic [2*XLEN-1:0] fifo_head;
    logic            accept, rsp_take, push;

    always_comb begin
        credit_used = {1'b0, outst_q} + {1'b0, fifo_count};
        // Gated by rst so the request drops the moment reset is asserted.
        imem_req_valid = rst && (state_q == ST_FETCH) && !redirect
                         && (credit_used < (CW+1)'(DEPTH));
        accept   = imem_req_valid && imem_req_ready;
        rsp_take = imem_rsp_valid && (outst_q != '0);
        push     = rsp_take && (state_q == ST_FETCH) && !redirect && !fifo_full;
        outst_d  = outst_q + CW'(accept) - CW'(rsp_take);

        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        state_d    = state_q;
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            rsp_pc_d   = word_align(redirect_pc);
            state_d    = (outst_d != '0) ? ST_DRAIN : ST_FETCH;
        end else begin
            if (accept) fetch_pc_d = next_pc(fetch_pc_q);
            if (push)   rsp_pc_d   = next_pc(rsp_pc_q);
            if ((state_q == ST_DRAIN) && (outst_d == '0)) state_d = ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_buf (
        .clk         (clk),
        .rst_ni      (rst),
        .push_i      (push),
        .push_data_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i       (out_ready),
        .flush_i     (redirect),
        .head_data_o (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign imem_addr        = fetch_pc_q;
    assign out_valid        = !fifo_empty;
    assign next_instruction = fifo_empty ? '0 : fifo_head[XLEN-1:0];
    assign instr_pc         = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: queue-based reference model, in-order memory
// with variable latency, directed corner sequences and a random soak.
module tb_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] next_instruction, instr_pc;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .next_instruction (next_instruction),
        .instr_pc         (instr_pc)
    );

    typedef struct { logic [31:0] pc; logic stale; } model_req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } buf_entry_t;
    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] target; logic [31:0] exp_first; logic [31:0] exp_second; } redir_vec_t;

    model_req_t  inflight[$];
    buf_entry_t  fifo_m[$];
    mem_req_t    mem_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pc_log[$];
    logic [31:0] model_pc;
    redir_vec_t  vecs[5];

    int   cyc, n_checks, n_errors;
    int   rsp_pct, lat_min, lat_max;
    logic drv_redirect, drv_out_ready, drv_req_ready, drv_spurious;
    logic [31:0] drv_redirect_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] req_at(input int idx);
        return (idx < req_log.size()) ? req_log[idx] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pc_at(input int idx);
        return (idx < pc_log.size()) ? pc_log[idx] : 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare at mid-cycle, advance model and memory.
    task automatic step();
        logic give, exp_req, acc_model;
        logic [31:0] exp_instr, exp_pc;
        int stale_n;
        redirect       = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        out_ready      = drv_out_ready;
        imem_req_ready = drv_req_ready;
        give = 1'b0;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc && $urandom_range(99) < rsp_pct) give = 1'b1;
        end else if (drv_spurious) begin
            give = 1'b1;
        end
        imem_rsp_valid = give;
        imem_rsp_data  = (give && mem_q.size() > 0) ? mem_word(mem_q[0].addr) : $urandom;
        #3;
        stale_n = 0;
        foreach (inflight[i]) if (inflight[i].stale) stale_n++;
        exp_req = !drv_redirect && (stale_n == 0) && (inflight.size() + fifo_m.size() < DEPTH);
        exp_instr = 32'h0;
        exp_pc    = 32'h0;
        if (fifo_m.size() > 0) begin
            exp_instr = fifo_m[0].data;
            exp_pc    = fifo_m[0].pc;
        end
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req && imem_req_valid) check("req_addr", imem_addr, model_pc);
        check("out_valid", 32'(out_valid), 32'(fifo_m.size() > 0));
        check("next_instruction", next_instruction, exp_instr);
        check("instr_pc", instr_pc, exp_pc);

        if (give && mem_q.size() > 0) void'(mem_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{imem_addr, cyc + $urandom_range(lat_max, lat_min)});
            req_log.push_back(imem_addr);
        end
        if (out_valid && out_ready) pc_log.push_back(instr_pc);

        acc_model = exp_req && drv_req_ready;
        if (fifo_m.size() > 0 && drv_out_ready) void'(fifo_m.pop_front());
        if (give && inflight.size() > 0) begin
            model_req_t r;
            r = inflight.pop_front();
            if (!r.stale && !drv_redirect) fifo_m.push_back('{r.pc, mem_word(r.pc)});
        end
        if (drv_redirect) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            fifo_m.delete();
            model_pc = drv_redirect_pc & 32'hFFFF_FFFC;
        end else if (acc_model) begin
            inflight.push_back('{model_pc, 1'b0});
            model_pc = model_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input string tag);
        rst            = 1'b0;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_next_instruction"}, next_instruction, 32'h0);
        check({tag, "_instr_pc"}, instr_pc, 32'h0);
        $display("reset %s: req_valid=%0b out_valid=%0b instr=%h pc=%h", tag,
                 imem_req_valid, out_valid, next_instruction, instr_pc);
        inflight.delete();
        fifo_m.delete();
        mem_q.delete();
        model_pc = RESET_PC;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic redirect_now(input logic [31:0] target);
        drv_redirect    = 1'b1;
        drv_redirect_pc = target;
        step();
        drv_redirect    = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_first, exp_next;
        bit found;
        int accepted;
        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0004};
        vecs[4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004};

        n_checks = 0; n_errors = 0; cyc = 0;
        drv_redirect = 1'b0; drv_redirect_pc = 32'h0; drv_spurious = 1'b0;
        drv_out_ready = 1'b1; drv_req_ready = 1'b1;
        rsp_pct = 100; lat_min = 1; lat_max = 1;
        out_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_data = 32'h0; redirect_pc = 32'h0;
        do_reset("power_on");

        // Straight-line fetch with a one-cycle memory.
        req_log.delete(); pc_log.delete();
        repeat (10) step();
        for (int k = 0; k < 3; k++) begin
            check("basic_req_addr", req_at(k), 32'(4 * k));
            check("basic_decode_pc", pc_at(k), 32'(4 * k));
            $display("basic #%0d: req %h decode pc %h", k, req_at(k), pc_at(k));
        end

        // Decode stalled for ten cycles.
        drv_out_ready = 1'b0;
        req_log.delete();
        repeat (10) step();
        accepted = req_log.size();
        check("stall_accepts_le_depth", 32'(accepted <= DEPTH), 32'h1);
        exp_first = (fifo_m.size() > 0) ? fifo_m[0].pc : model_pc;
        drv_out_ready = 1'b1;
        pc_log.delete();
        repeat (10) step();
        for (int k = 0; k < 4; k++) check("stall_release_order", pc_at(k), exp_first + 32'(4 * k));
        $display("stall: %0d accepts while stalled, first after release %h", accepted, pc_at(0));

        // Redirect with two requests outstanding.
        do_reset("pre_redirect");
        lat_min = 4; lat_max = 4;
        repeat (2) step();
        redirect_now(32'h0000_0103);
        lat_min = 1; lat_max = 1;
        req_log.delete(); pc_log.delete();
        repeat (14) step();
        check("drain_first_req", req_at(0), 32'h0000_0100);
        check("drain_first_pc", pc_at(0), 32'h0000_0100);
        check("drain_second_pc", pc_at(1), 32'h0000_0104);
        $display("redirect 103: first req %h first pc %h", req_at(0), pc_at(0));

        // Redirect in the same cycle a response arrives.
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
            else step();
        end
        check("coincide_setup", 32'(found), 32'h1);
        redirect_now(32'h0000_2000);
        pc_log.delete();
        repeat (10) step();
        check("coincide_first_pc", pc_at(0), 32'h0000_2000);
        $display("redirect on response: first pc %h", pc_at(0));

        // Table of redirect targets, including alignment and address wrap.
        lat_min = 1; lat_max = 2;
        foreach (vecs[v]) begin
            redirect_now(vecs[v].target);
            req_log.delete(); pc_log.delete();
            repeat (12) step();
            check("vec_req0", req_at(0), vecs[v].exp_first);
            check("vec_req1", req_at(1), vecs[v].exp_second);
            check("vec_pc0", pc_at(0), vecs[v].exp_first);
            check("vec_pc1", pc_at(1), vecs[v].exp_second);
            $display("vec %0d: target %h reqs %h %h pcs %h %h", v, vecs[v].target,
                     req_at(0), req_at(1), pc_at(0), pc_at(1));
        end

        // Response with nothing outstanding is ignored.
        drv_req_ready = 1'b0;
        repeat (8) step();
        drv_spurious = 1'b1;
        repeat (2) step();
        drv_spurious = 1'b0;
        exp_next = model_pc;
        drv_req_ready = 1'b1;
        req_log.delete();
        repeat (3) step();
        check("spurious_next_req", req_at(0), exp_next);
        $display("spurious rsp: next req %h", req_at(0));

        // Reset with two requests in flight.
        lat_min = 6; lat_max = 6;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (inflight.size() == 2) found = 1'b1;
            else step();
        end
        check("two_outstanding_setup", 32'(found), 32'h1);
        do_reset("mid_flight");
        lat_min = 1; lat_max = 1;
        req_log.delete();
        repeat (3) step();
        check("post_reset_first_req", req_at(0), RESET_PC);
        $display("reset mid-flight: first req %h", req_at(0));

        // Random soak.
        rsp_pct = 70; lat_min = 1; lat_max = 3;
        for (int k = 0; k < 4000; k++) begin
            drv_redirect    = ($urandom_range(99) < 4);
            drv_redirect_pc = $urandom;
            drv_out_ready   = ($urandom_range(99) < 70);
            drv_req_ready   = ($urandom_range(99) < 75);
            step();
        end
        drv_redirect = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
